// File: rtl/thermo_fan_ctrl_if.sv
// Signal bundle between the configuration/board side and the thermal fan controller.
// The master drives the thermostat and config bits; the slave (the controller) returns fan status.
interface thermo_fan_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             THERMO;
    logic             AUTO_EN;
    logic             FORCE_REQ;
    logic             FAN_ON;
    logic             THERMO_DB;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] OVERHEAT_CNT;

    modport master (
        output THERMO,
        output AUTO_EN,
        output FORCE_REQ,
        input  FAN_ON,
        input  THERMO_DB,
        input  STATE,
        input  OVERHEAT_CNT
    );

    modport slave (
        input  THERMO,
        input  AUTO_EN,
        input  FORCE_REQ,
        output FAN_ON,
        output THERMO_DB,
        output STATE,
        output OVERHEAT_CNT
    );
endinterface

// File: rtl/thermo_fan_ctrl.sv
// Thermal fan controller: synchronises and debounces THERMO, runs the OFF/HOT/HOLD/FORCED
// state machine with a minimum fan hold time, and counts overheat entries for readback.
module thermo_fan_ctrl #(
    parameter int SYS_CLK_FREQ    = 20480000,
    parameter int TICK_CYCLES     = SYS_CLK_FREQ / 1000,
    parameter int DEBOUNCE_CYCLES = 2048,
    parameter int MIN_ON_MS       = 5000,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    thermo_fan_ctrl_if.slave bus
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_HOT    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_FORCED = 2'd3;

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (MIN_ON_MS > 0) ? $clog2(MIN_ON_MS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_ON_MS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // All-ones is sticky so readback never wraps back to a small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    logic              sync1_r;
    logic              sync2_r;
    logic              thermo_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_cnt_s;
    logic              thermo_db_r;
    logic              thermo_db_s;
    logic [TICK_W-1:0] pre_r;
    logic [TICK_W-1:0] pre_s;
    logic              tick_s;
    logic              hot_s;
    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              fan_r;
    logic              fan_s;

    assign thermo_s = sync2_r;
    assign hot_s    = bus.AUTO_EN & thermo_db_r;

    // Two-flop synchroniser for the asynchronous thermostat input.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.THERMO;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        db_cnt_s    = db_cnt_r;
        thermo_db_s = thermo_db_r;
        if (thermo_s == thermo_db_r) begin
            db_cnt_s = '0;
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_s    = '0;
            thermo_db_s = ~thermo_db_r;
        end else begin
            db_cnt_s = db_cnt_r + DB_ONE;
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            db_cnt_r    <= '0;
            thermo_db_r <= 1'b0;
        end else begin
            db_cnt_r    <= db_cnt_s;
            thermo_db_r <= thermo_db_s;
        end
    end

    // Free-running 1 ms prescaler; the state machine never restarts it.
    always_comb begin
        tick_s = (pre_r == TICK_LAST);
        if (tick_s) begin
            pre_s = '0;
        end else begin
            pre_s = pre_r + TICK_ONE;
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_s;
        end
    end

    // Fan state machine; FORCE_REQ outranks everything and a reload masks a coincident tick.
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_OFF: begin
                if (bus.FORCE_REQ) begin
                    state_s = ST_FORCED;
                end else if (hot_s) begin
                    state_s = ST_HOT;
                    cnt_s   = sat_inc(cnt_r);
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_HOT: begin
                if (bus.FORCE_REQ) begin
                    state_s = ST_FORCED;
                end else if (!hot_s) begin
                    state_s = ST_HOLD;
                    hold_s  = HOLD_LOAD;
                end else begin
                    state_s = ST_HOT;
                end
            end
            ST_HOLD: begin
                if (bus.FORCE_REQ) begin
                    state_s = ST_FORCED;
                end else if (hot_s) begin
                    state_s = ST_HOT;
                end else if ((hold_r == HOLD_ZERO) || (tick_s && (hold_r == HOLD_ONE))) begin
                    state_s = ST_OFF;
                end else if (tick_s) begin
                    hold_s = hold_r - HOLD_ONE;
                end else begin
                    hold_s = hold_r;
                end
            end
            ST_FORCED: begin
                if (!bus.FORCE_REQ) begin
                    state_s = ST_HOLD;
                    hold_s  = HOLD_LOAD;
                end else begin
                    state_s = ST_FORCED;
                end
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
        fan_s = (state_s != ST_OFF);
    end

    // State, hold timer, event counter and fan drive all update on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_OFF;
            hold_r  <= '0;
            cnt_r   <= '0;
            fan_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            hold_r  <= hold_s;
            cnt_r   <= cnt_s;
            fan_r   <= fan_s;
        end
    end

    assign bus.FAN_ON       = fan_r;
    assign bus.THERMO_DB    = thermo_db_r;
    assign bus.STATE        = state_r;
    assign bus.OVERHEAT_CNT = cnt_r;

endmodule

// File: tb/tb_thermo_fan_ctrl.sv
// Self-checking bench for thermo_fan_ctrl: directed scenarios plus random stimulus compared
// cycle by cycle against a behavioural model of the fan controller rules.
module tb_thermo_fan_ctrl;

    localparam int DB  = 4;
    localparam int TK  = 10;
    localparam int MON = 3;

    logic CLK       = 1'b0;
    logic RESET_N   = 1'b0;
    logic thermo    = 1'b0;
    logic auto_en   = 1'b0;
    logic force_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    thermo_fan_ctrl_if #(.CNT_W(16)) bus ();
    thermo_fan_ctrl_if #(.CNT_W(4))  bus_s ();

    assign bus.THERMO      = thermo;
    assign bus.AUTO_EN     = auto_en;
    assign bus.FORCE_REQ   = force_req;
    assign bus_s.THERMO    = thermo;
    assign bus_s.AUTO_EN   = auto_en;
    assign bus_s.FORCE_REQ = force_req;

    thermo_fan_ctrl #(
        .SYS_CLK_FREQ(10000), .TICK_CYCLES(TK), .DEBOUNCE_CYCLES(DB), .MIN_ON_MS(MON), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus.slave)
    );

    // Narrow-counter copy so counter saturation is reachable in a short run.
    thermo_fan_ctrl #(
        .SYS_CLK_FREQ(10000), .TICK_CYCLES(TK), .DEBOUNCE_CYCLES(DB), .MIN_ON_MS(MON), .CNT_W(4)
    ) dut_s (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus_s.slave)
    );

    always #5 CLK = ~CLK;

    logic [23:0] dut_vec;
    assign dut_vec = {bus.FAN_ON, bus.THERMO_DB, bus.STATE, bus.OVERHEAT_CNT, bus_s.OVERHEAT_CNT};

    // Behavioural model: raw-sample history, run length of differing samples, ms timer, etc.
    int m_s1, m_s2, m_db, m_run, m_pre, m_state, m_hold, m_cnt, m_cnt_s, m_fan;

    function automatic logic [23:0] model_vec();
        return {1'(m_fan), 1'(m_db), 2'(m_state), 16'(m_cnt), 4'(m_cnt_s)};
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_pre = 0;
        m_state = 0; m_hold = 0; m_cnt = 0; m_cnt_s = 0; m_fan = 0;
    endtask

    task automatic step();
        int  ns;
        int  nh;
        bit  tick;
        bit  hot;
        @(posedge CLK);
        if (!RESET_N) begin
            model_reset();
        end else begin
            tick = (m_pre == TK - 1);
            hot  = (auto_en === 1'b1) && (m_db == 1);
            ns = m_state;
            nh = m_hold;
            if (force_req === 1'b1) begin
                if (m_state != 3) ns = 3;
            end else begin
                case (m_state)
                    0: if (hot) begin
                           ns = 1;
                           if (m_cnt < 65535) m_cnt = m_cnt + 1;
                           if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
                       end
                    1: if (!hot) begin ns = 2; nh = MON; end
                    2: if (hot) ns = 1;
                       else if (m_hold == 0 || (tick && m_hold == 1)) ns = 0;
                       else if (tick) nh = m_hold - 1;
                    default: begin ns = 2; nh = MON; end
                endcase
            end
            if (m_s2 != m_db) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_db  = 1 - m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = (thermo === 1'b1) ? 1 : 0;
            m_pre = (m_pre + 1) % TK;
            m_state = ns;
            m_hold = nh;
            m_fan = (ns != 0) ? 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        auto_en = 1'b1;
        thermo  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        n_checks++;
        if ({bus.FAN_ON, bus.STATE, bus.OVERHEAT_CNT} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0", {bus.FAN_ON, bus.STATE, bus.OVERHEAT_CNT});
        end
    endtask

    task automatic test_rise_fall();
        int db_lat = -1, fan_lat = -1, hold_at = -1, off_at = -1;
        thermo = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL rise cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (db_lat < 0 && bus.THERMO_DB === 1'b1) db_lat = i;
            if (fan_lat < 0 && bus.FAN_ON === 1'b1) fan_lat = i;
        end
        n_checks++;
        if (fan_lat != 7 || db_lat != 6) begin
            n_fail++;
            $display("FAIL rise_latency: got db %0d fan %0d expected db 6 fan 7", db_lat, fan_lat);
        end
        n_checks++;
        if (bus.STATE !== 2'd1 || bus.OVERHEAT_CNT !== 16'd1) begin
            n_fail++;
            $display("FAIL rise_hot: got state %0d cnt %0d expected state 1 cnt 1", bus.STATE, bus.OVERHEAT_CNT);
        end
        thermo = 1'b0;
        for (int i = 1; i <= 80 && off_at < 0; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL fall cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (hold_at < 0 && bus.STATE === 2'd2) hold_at = i;
            if (hold_at >= 0 && off_at < 0 && bus.STATE === 2'd0) off_at = i;
        end
        n_checks++;
        if (hold_at != 7 || off_at < 0 || (off_at - hold_at) < 20 || (off_at - hold_at) > 30) begin
            n_fail++;
            $display("FAIL hold_duration: got hold_at %0d off_at %0d expected hold_at 7 and 20..30 cycles in HOLD",
                     hold_at, off_at);
        end
    endtask

    task automatic test_glitch();
        int len;
        int cnt_before;
        for (int p = 0; p < 2; p++) begin
            len = (p == 0) ? 3 : $urandom_range(1, 3);
            thermo = 1'b1;
            for (int i = 0; i < len + 10; i++) begin
                if (i == len) thermo = 1'b0;
                step();
                n_checks++;
                if (dut_vec !== model_vec() || bus.THERMO_DB !== 1'b0 || bus.FAN_ON !== 1'b0) begin
                    n_fail++;
                    $display("FAIL short_glitch len %0d cycle %0d: got %h expected %h with db/fan low",
                             len, i, dut_vec, model_vec());
                end
            end
        end
        cnt_before = m_cnt;
        thermo = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 6) thermo = 1'b0;
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL long_glitch cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (bus.OVERHEAT_CNT !== 16'(cnt_before + 1) || bus.STATE !== 2'd0) begin
            n_fail++;
            $display("FAIL long_glitch_count: got cnt %0d state %0d expected cnt %0d state 0",
                     bus.OVERHEAT_CNT, bus.STATE, cnt_before + 1);
        end
    endtask

    task automatic test_rehot();
        int cnt_before;
        bit dropped = 1'b0;
        thermo = 1'b1;
        for (int i = 0; i < 20 && m_state != 1; i++) step();
        cnt_before = m_cnt;
        thermo = 1'b0;
        for (int i = 0; i < 20 && m_state != 2; i++) step();
        for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
            step();
            if (bus.FAN_ON !== 1'b1) dropped = 1'b1;
        end
        thermo = 1'b1;
        for (int i = 0; i < 20 && m_state != 1; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL rehot cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (bus.FAN_ON !== 1'b1) dropped = 1'b1;
        end
        n_checks++;
        if (bus.STATE !== 2'd1 || bus.OVERHEAT_CNT !== 16'(cnt_before) || dropped) begin
            n_fail++;
            $display("FAIL rehot_result: got state %0d cnt %0d dropped %0d expected state 1 cnt %0d dropped 0",
                     bus.STATE, bus.OVERHEAT_CNT, dropped, cnt_before);
        end
        thermo = 1'b0;
        for (int i = 0; i < 80 && m_state != 0; i++) step();
    endtask

    task automatic test_force();
        int off_at = -1;
        auto_en   = 1'b0;
        force_req = 1'b1;
        step();
        n_checks++;
        if (bus.STATE !== 2'd3 || bus.FAN_ON !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL force_on: got state %0d fan %0d expected state 3 fan 1", bus.STATE, bus.FAN_ON);
        end
        force_req = 1'b0;
        step();
        n_checks++;
        if (bus.STATE !== 2'd2 || bus.FAN_ON !== 1'b1) begin
            n_fail++;
            $display("FAIL force_release: got state %0d fan %0d expected state 2 fan 1", bus.STATE, bus.FAN_ON);
        end
        for (int i = 1; i <= 40 && off_at < 0; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL force_hold cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (bus.STATE === 2'd0) off_at = i;
        end
        n_checks++;
        if (off_at < 0 || off_at > 30) begin
            n_fail++;
            $display("FAIL force_off_time: got %0d cycles expected 1..30", off_at);
        end
        auto_en = 1'b1;
        thermo  = 1'b1;
        for (int i = 0; i < 20 && m_state != 1; i++) step();
        force_req = 1'b1;
        step();
        n_checks++;
        if (bus.STATE !== 2'd3 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL force_from_hot: got state %0d expected 3", bus.STATE);
        end
        force_req = 1'b0;
        thermo    = 1'b0;
        for (int i = 0; i < 80 && m_state != 0; i++) step();
    endtask

    task automatic test_saturation();
        int cnt_before;
        thermo  = 1'b1;
        auto_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        cnt_before = m_cnt;
        for (int e = 0; e < 20; e++) begin
            auto_en = 1'b1;
            step();
            auto_en = 1'b0;
            for (int i = 0; i < 40 && m_state != 0; i++) begin
                step();
                n_checks++;
                if (dut_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL saturation event %0d: got %h expected %h", e, dut_vec, model_vec());
                end
            end
        end
        n_checks++;
        if (bus_s.OVERHEAT_CNT !== 4'hF || bus.OVERHEAT_CNT !== 16'(cnt_before + 20)) begin
            n_fail++;
            $display("FAIL saturation_final: got narrow %h wide %0d expected narrow f wide %0d",
                     bus_s.OVERHEAT_CNT, bus.OVERHEAT_CNT, cnt_before + 20);
        end
    endtask

    task automatic test_async_reset();
        auto_en = 1'b1;
        step();
        auto_en = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.STATE !== 2'd2 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL async_setup: got state %0d expected 2", bus.STATE);
        end
        #3;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({bus.FAN_ON, bus.THERMO_DB, bus.STATE, bus.OVERHEAT_CNT, bus_s.OVERHEAT_CNT} !== 24'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0",
                     {bus.FAN_ON, bus.THERMO_DB, bus.STATE, bus.OVERHEAT_CNT, bus_s.OVERHEAT_CNT});
        end
        model_reset();
        #12;
        RESET_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int th_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (th_left == 0) begin
                thermo  = 1'($urandom_range(0, 1));
                th_left = $urandom_range(1, 12);
            end else begin
                th_left--;
            end
            if ($urandom_range(0, 39) == 0) force_req = ~force_req;
            if ($urandom_range(0, 29) == 0) auto_en = ~auto_en;
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        #22;
        RESET_N = 1'b1;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_rehot();
        test_force();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
